branch_redirect_unit: RTL and testbench

BRANCH_REDIRECT_UNIT -- requirements
Module: branch_redirect_unit

---
 rtl/riscv_branch_pkg.sv | 21 ++
 rtl/branch_imm_gen.sv | 16 +
 rtl/branch_redirect_unit.sv | 143 ++++++++++++++
 tb/tb_branch_redirect_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_branch_pkg.sv
// Shared RV64I control-transfer constants and the redirect-unit state encoding.
package riscv_branch_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_JALR = 3'b000;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SHADOW = 1'b1
    } state_e;

endpackage

// File: rtl/branch_imm_gen.sv
// Combinational B/J/I immediate extraction, sign-extended to XLEN.
// Only instruction bits [31:7] carry immediate fields, so the opcode is not an input.
module branch_imm_gen #(
    parameter int XLEN = 64
) (
    input  logic [31:7]     insn_i,
    output logic [XLEN-1:0] imm_b_o,
    output logic [XLEN-1:0] imm_j_o,
    output logic [XLEN-1:0] imm_i_o
);

    assign imm_b_o = {{(XLEN-12){insn_i[31]}}, insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
    assign imm_j_o = {{(XLEN-20){insn_i[31]}}, insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};
    assign imm_i_o = {{(XLEN-11){insn_i[31]}}, insn_i[30:20]};

endmodule

// File: rtl/branch_redirect_unit.sv
// Resolves branches/jumps, issues a one-cycle fetch redirect and holds a
// squash shadow of SQUASH_CYCLES cycles during which new input is ignored.
module branch_redirect_unit
    import riscv_branch_pkg::*;
#(
    parameter int XLEN          = 64,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] pc_branch,
    output logic            select,
    output logic            squash,
    output logic            misalign,
    output logic [15:0]     redirect_count
);

    localparam logic [3:0] SHADOW_LOAD = 4'(SQUASH_CYCLES - 1);

    logic [XLEN-1:0] imm_b_s, imm_j_s, imm_i_s, jalr_sum_s, target_s;
    logic            taken_s;
    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;

    state_e          state_q, state_d;
    logic [3:0]      shadow_cnt_q, shadow_cnt_d;
    logic [XLEN-1:0] pc_branch_q, pc_branch_d;
    logic            select_q, select_d;
    logic            squash_q, squash_d;
    logic            misalign_q, misalign_d;
    logic [15:0]     count_q, count_d;

    branch_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .insn_i  (instruction[31:7]),
        .imm_b_o (imm_b_s),
        .imm_j_o (imm_j_s),
        .imm_i_o (imm_i_s)
    );

    assign opcode_s   = instruction[6:0];
    assign funct3_s   = instruction[14:12];
    assign jalr_sum_s = rs1_data + imm_i_s;

    // Branch condition evaluation and target selection.
    always_comb begin
        taken_s  = 1'b0;
        target_s = pc + imm_b_s;
        case (opcode_s)
            OPC_BRANCH: begin
                case (funct3_s)
                    F3_BEQ:  taken_s = (rs1_data == rs2_data);
                    F3_BNE:  taken_s = (rs1_data != rs2_data);
                    F3_BLT:  taken_s = ($signed(rs1_data) <  $signed(rs2_data));
                    F3_BGE:  taken_s = ($signed(rs1_data) >= $signed(rs2_data));
                    F3_BLTU: taken_s = (rs1_data <  rs2_data);
                    F3_BGEU: taken_s = (rs1_data >= rs2_data);
                    default: taken_s = 1'b0;
                endcase
            end
            OPC_JAL: begin
                taken_s  = 1'b1;
                target_s = pc + imm_j_s;
            end
            OPC_JALR: begin
                taken_s  = (funct3_s == F3_JALR);
                target_s = jalr_sum_s & {{(XLEN-1){1'b1}}, 1'b0};
            end
            default: taken_s = 1'b0;
        endcase
    end

    // Next-state logic: redirect or misalign from RUN, count down the shadow.
    always_comb begin
        state_d      = state_q;
        shadow_cnt_d = shadow_cnt_q;
        pc_branch_d  = pc_branch_q;
        select_d     = 1'b0;
        misalign_d   = 1'b0;
        count_d      = count_q;
        case (state_q)
            ST_RUN: begin
                if (valid_in && taken_s) begin
                    if (target_s[1]) begin
                        misalign_d = 1'b1;
                    end else begin
                        select_d     = 1'b1;
                        pc_branch_d  = target_s;
                        count_d      = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                        state_d      = ST_SHADOW;
                        shadow_cnt_d = SHADOW_LOAD;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_SHADOW: begin
                if (shadow_cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    shadow_cnt_d = shadow_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d      = ST_RUN;
                shadow_cnt_d = 4'd0;
            end
        endcase
        squash_d = (state_d == ST_SHADOW);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            shadow_cnt_q <= 4'd0;
            pc_branch_q  <= '0;
            select_q     <= 1'b0;
            squash_q     <= 1'b0;
            misalign_q   <= 1'b0;
            count_q      <= 16'd0;
        end else begin
            state_q      <= state_d;
            shadow_cnt_q <= shadow_cnt_d;
            pc_branch_q  <= pc_branch_d;
            select_q     <= select_d;
            squash_q     <= squash_d;
            misalign_q   <= misalign_d;
            count_q      <= count_d;
        end
    end

    assign pc_branch      = pc_branch_q;
    assign select         = select_q;
    assign squash         = squash_q;
    assign misalign       = misalign_q;
    assign redirect_count = count_q;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Scoreboard bench for branch_redirect_unit: a cycle model pushes expected
// outputs as stimulus is driven; they are popped and compared after each edge.
module tb_branch_redirect_unit;

    localparam int XLEN = 64;
    localparam int SC   = 2;

    typedef struct packed {
        logic [63:0] pcb;
        logic        sel;
        logic        sq;
        logic        mis;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] instruction;
    logic [63:0] pc, rs1_data, rs2_data;
    logic [63:0] pc_branch;
    logic        select, squash, misalign;
    logic [15:0] redirect_count;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    string       ctx = "init";

    logic [63:0] m_pcb;
    logic        m_sel, m_mis;
    logic [15:0] m_cnt;
    int          m_left;

    branch_redirect_unit #(.XLEN(XLEN), .SQUASH_CYCLES(SC)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .instruction    (instruction),
        .pc             (pc),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .pc_branch      (pc_branch),
        .select         (select),
        .squash         (squash),
        .misalign       (misalign),
        .redirect_count (redirect_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jal(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [11:0] imm, input logic [2:0] f3);
        return {imm, 5'd1, f3, 5'd1, 7'b1100111};
    endfunction

    task automatic ref_decode(input logic [31:0] ins, input logic [63:0] p, input logic [63:0] a,
                              input logic [63:0] b, output bit tk, output logic [63:0] tg);
        logic signed [12:0] ib;
        logic signed [20:0] ij;
        logic signed [11:0] ii;
        logic signed [63:0] sx;
        tk = 1'b0;
        tg = 64'd0;
        ib = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ij = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        ii = ins[31:20];
        if (ins[6:0] == 7'b1100011) begin
            sx = ib;
            tg = p + sx;
            case (ins[14:12])
                3'd0:    tk = (a == b);
                3'd1:    tk = (a != b);
                3'd4:    tk = ($signed(a) <  $signed(b));
                3'd5:    tk = ($signed(a) >= $signed(b));
                3'd6:    tk = (a <  b);
                3'd7:    tk = (a >= b);
                default: tk = 1'b0;
            endcase
        end else if (ins[6:0] == 7'b1101111) begin
            sx = ij;
            tg = p + sx;
            tk = 1'b1;
        end else if (ins[6:0] == 7'b1100111 && ins[14:12] == 3'd0) begin
            sx = ii;
            tg = (a + sx) & ~64'd1;
            tk = 1'b1;
        end else begin
            tk = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_pcb  = 64'd0;
        m_sel  = 1'b0;
        m_mis  = 1'b0;
        m_cnt  = 16'd0;
        m_left = 0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.pcb = m_pcb;
        e.sel = m_sel;
        e.sq  = (m_left > 0);
        e.mis = m_mis;
        e.cnt = m_cnt;
        sb_q.push_back(e);
    endtask

    task automatic model_step(input logic v, input logic [31:0] ins, input logic [63:0] p,
                              input logic [63:0] a, input logic [63:0] b);
        bit          tk;
        logic [63:0] tg;
        ref_decode(ins, p, a, b, tk, tg);
        m_sel = 1'b0;
        m_mis = 1'b0;
        if (m_left > 0) begin
            m_left--;
        end else if (v && tk) begin
            if (tg[1]) begin
                m_mis = 1'b1;
            end else begin
                m_sel  = 1'b1;
                m_pcb  = tg;
                m_left = SC;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
        end
        push_exp();
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.scoreboard got=empty want=entry", ctx);
        end else begin
            e = sb_q.pop_front();
            check_eq({ctx, ".pc_branch"}, pc_branch, e.pcb);
            check_eq({ctx, ".select"}, {63'd0, select}, {63'd0, e.sel});
            check_eq({ctx, ".squash"}, {63'd0, squash}, {63'd0, e.sq});
            check_eq({ctx, ".misalign"}, {63'd0, misalign}, {63'd0, e.mis});
            check_eq({ctx, ".count"}, {48'd0, redirect_count}, {48'd0, e.cnt});
        end
    endtask

    task automatic run_cycle(input logic v, input logic [31:0] ins, input logic [63:0] p,
                             input logic [63:0] a, input logic [63:0] b);
        valid_in    = v;
        instruction = ins;
        pc          = p;
        rs1_data    = a;
        rs2_data    = b;
        model_step(v, ins, p, a, b);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 32'h0000_0013, 64'd0, 64'd0, 64'd0);
    endtask

    initial begin
        logic [31:0] ins;
        logic [2:0]  f3;
        int          op;

        reset = 1'b1; valid_in = 1'b0; instruction = 32'd0;
        pc = 64'd0; rs1_data = 64'd0; rs2_data = 64'd0;
        model_reset();
        #1;
        ctx = "reset";
        push_exp();
        compare_out();
        @(negedge clk);
        reset = 1'b0;

        ctx = "beq";
        run_cycle(1'b1, enc_b(3'b000, 13'd16), 64'h100, 64'd5, 64'd5);
        check_eq("beq.target", pc_branch, 64'h110);
        check_eq("beq.cnt", {48'd0, redirect_count}, 64'd1);
        check_eq("beq.squash1", {63'd0, squash}, 64'd1);
        idle(1);
        check_eq("beq.squash2", {63'd0, squash}, 64'd1);
        idle(1);
        check_eq("beq.squash_end", {63'd0, squash}, 64'd0);

        ctx = "bne";
        run_cycle(1'b1, enc_b(3'b001, 13'd16), 64'h300, 64'd7, 64'd7);
        check_eq("bne.select", {63'd0, select}, 64'd0);
        check_eq("bne.hold", pc_branch, 64'h110);

        ctx = "jalr";
        run_cycle(1'b1, enc_jalr(12'd8, 3'b000), 64'h500, 64'h2001, 64'd0);
        check_eq("jalr.target", pc_branch, 64'h2008);
        idle(2);

        ctx = "wrap";
        run_cycle(1'b1, enc_b(3'b000, 13'h1FFC), 64'h0, 64'd3, 64'd3);
        check_eq("wrap.target", pc_branch, 64'hFFFF_FFFF_FFFF_FFFC);
        idle(2);

        ctx = "misalign";
        run_cycle(1'b1, enc_jal(21'd2), 64'h100, 64'd0, 64'd0);
        check_eq("misalign.pulse", {63'd0, misalign}, 64'd1);
        check_eq("misalign.nosel", {63'd0, select}, 64'd0);
        idle(1);

        ctx = "shadow_jal";
        run_cycle(1'b1, enc_b(3'b000, 13'd32), 64'h1000, 64'd1, 64'd1);
        run_cycle(1'b1, enc_jal(21'd64), 64'h1004, 64'd0, 64'd0);
        check_eq("shadow_jal.nosel", {63'd0, select}, 64'd0);
        check_eq("shadow_jal.target", pc_branch, 64'h1020);
        idle(2);

        ctx = "cmp";
        run_cycle(1'b1, enc_b(3'b100, 13'd8), 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        idle(2);
        run_cycle(1'b1, enc_b(3'b110, 13'd8), 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        run_cycle(1'b1, enc_b(3'b101, 13'd8), 64'h40, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(2);
        run_cycle(1'b1, enc_b(3'b111, 13'd8), 64'h40, 64'd1, 64'd2);
        run_cycle(1'b1, enc_b(3'b010, 13'd8), 64'h40, 64'd1, 64'd1);
        run_cycle(1'b1, 32'h0050_0093, 64'h40, 64'd1, 64'd1);

        ctx = "rst_shadow";
        run_cycle(1'b1, enc_b(3'b000, 13'd16), 64'h100, 64'd5, 64'd5);
        reset = 1'b1;
        model_reset();
        push_exp();
        #2;
        compare_out();
        check_eq("rst_shadow.squash", {63'd0, squash}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        ctx = "bltu_after_rst";
        run_cycle(1'b1, enc_b(3'b110, 13'd32), 64'h200, 64'd1, 64'd2);
        check_eq("bltu_after_rst.select", {63'd0, select}, 64'd1);
        check_eq("bltu_after_rst.target", pc_branch, 64'h220);
        idle(2);

        ctx = "rand";
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 8);
            f3 = 3'($urandom_range(0, 7));
            case (op)
                6:       ins = enc_jal({8'd0, 12'($urandom_range(0, 4095)), 1'b0});
                7:       ins = enc_jalr(12'($urandom_range(0, 4095)), ($urandom_range(0, 3) == 0) ? f3 : 3'd0);
                8:       ins = 32'h0050_0093;
                default: ins = enc_b(f3, {12'($urandom_range(0, 4095)), 1'b0});
            endcase
            run_cycle(($urandom_range(0, 3) != 0), ins, {32'd0, $urandom} & ~64'd3,
                      64'($urandom_range(0, 3)) - 64'd1, 64'($urandom_range(0, 3)) - 64'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
